// File: rtl/mask_enc_pkg.sv
// Shared types and defaults for the mask encoder.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package mask_enc_pkg;

    localparam int N_DEF    = 32;
    localparam int IDXW_DEF = 5;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

endpackage

// File: rtl/mask_encoder_32x5_prio_enc32.sv
// Combinational priority encoder: index of the lowest (or highest) set bit of vec.
// Latency: 0 cycles, purely combinational.
// Backpressure: none; the caller decides when idx is consumed.
//
// Ports:
//   vec        in   N     bit vector to encode
//   msb_first  in   1     0: report lowest set bit, 1: report highest set bit
//   idx        out  IDXW  encoded index, 0 when no bit is set
//   any        out  1     at least one bit of vec is set
module prio_enc32 #(
    parameter int N    = mask_enc_pkg::N_DEF,
    parameter int IDXW = mask_enc_pkg::IDXW_DEF
) (
    input  logic [N-1:0]    vec,
    input  logic            msb_first,
    output logic [IDXW-1:0] idx,
    output logic            any
);

    // The last matching iteration wins, so the scan direction picks
    // which end of the vector has priority.
    always_comb begin
        idx = '0;
        any = |vec;
        if (msb_first) begin
            for (int i = 0; i < N; i++) begin
                if (vec[i]) idx = IDXW'(i);
            end
        end else begin
            for (int i = N - 1; i >= 0; i--) begin
                if (vec[i]) idx = IDXW'(i);
            end
        end
    end

endmodule

// File: rtl/mask_encoder_32x5.sv
// Walks a request mask and streams out the index of every set bit, one per beat.
// Latency: first index valid the cycle after the mask is accepted; one IDLE bubble between masks.
// Backpressure: out_ready low holds out_idx/out_last/pending stable; in_ready is low while scanning.
//
// Ports:
//   clk, rst               clock (rising edge), asynchronous active-high reset
//   in_valid/in_ready      mask handshake; in_mask sampled only on the accepting edge
//   in_mask                set bits to be encoded
//   flush                  synchronous abort, beats in the flush cycle are not taken
//   out_valid/out_ready    index handshake
//   out_idx, out_last      current index, and flag for the final set bit of the mask
//   empty_pls              one-cycle pulse after an all-zero mask is accepted
//   emit_cnt               indices emitted so far for the current mask
module mask_encoder_32x5
    import mask_enc_pkg::*;
#(
    parameter int N         = N_DEF,
    parameter int IDXW      = IDXW_DEF,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [N-1:0]    in_mask,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [IDXW-1:0] out_idx,
    output logic            out_last,
    output logic            empty_pls,
    output logic [5:0]      emit_cnt
);

    if (IDXW != $clog2(N)) begin : g_bad_idxw
        $fatal(1, "mask_encoder_32x5: IDXW must equal clog2(N)");
    end
    if (N < 2 || N > 32 || (N & (N - 1)) != 0) begin : g_bad_n
        $fatal(1, "mask_encoder_32x5: N must be a power of two in 2..32");
    end

    state_t          state;
    logic [N-1:0]    pending;
    logic [IDXW-1:0] enc_idx;
    logic            pend_any;
    logic            single;
    logic [N-1:0]    clr_mask;
    logic            beat;

    prio_enc32 #(
        .N    (N),
        .IDXW (IDXW)
    ) u_enc (
        .vec       (pending),
        .msb_first (MSB_FIRST),
        .idx       (enc_idx),
        .any       (pend_any)
    );

    // Exactly one bit left: clearing the lowest set bit leaves nothing.
    assign single   = (pending & (pending - N'(1))) == '0;
    assign clr_mask = N'(1) << enc_idx;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == SCAN) && pend_any;
    assign out_idx   = out_valid ? enc_idx : '0;
    assign out_last  = out_valid && single;
    assign beat      = out_valid && out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            pending   <= '0;
            emit_cnt  <= '0;
            empty_pls <= 1'b0;
        end else begin
            empty_pls <= 1'b0;
            if (flush) begin
                // Flush overrides any handshake on either side this cycle.
                state    <= IDLE;
                pending  <= '0;
                emit_cnt <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (in_valid) begin
                            emit_cnt <= '0;
                            if (in_mask != '0) begin
                                pending <= in_mask;
                                state   <= SCAN;
                            end else begin
                                empty_pls <= 1'b1;
                            end
                        end
                    end
                    SCAN: begin
                        if (beat) begin
                            pending  <= pending & ~clr_mask;
                            emit_cnt <= emit_cnt + 6'd1;
                            if (single) state <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mask_encoder_32x5.sv
module tb_mask_encoder_32x5;

    typedef struct packed {
        logic [4:0] idx;
        logic       last;
        logic [5:0] cnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // LSB-first instance
    logic        in_valid0 = 1'b0, flush0 = 1'b0, out_ready0 = 1'b1;
    logic [31:0] in_mask0 = '0;
    logic        in_ready0, out_valid0, out_last0, empty_pls0;
    logic [4:0]  out_idx0;
    logic [5:0]  emit_cnt0;

    // MSB-first instance
    logic        in_valid1 = 1'b0, flush1 = 1'b0, out_ready1 = 1'b1;
    logic [31:0] in_mask1 = '0;
    logic        in_ready1, out_valid1, out_last1, empty_pls1;
    logic [4:0]  out_idx1;
    logic [5:0]  emit_cnt1;

    mask_encoder_32x5 #(.N(32), .IDXW(5), .MSB_FIRST(1'b0)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid0), .in_ready(in_ready0),
        .in_mask(in_mask0), .flush(flush0), .out_valid(out_valid0),
        .out_ready(out_ready0), .out_idx(out_idx0), .out_last(out_last0),
        .empty_pls(empty_pls0), .emit_cnt(emit_cnt0)
    );

    mask_encoder_32x5 #(.N(32), .IDXW(5), .MSB_FIRST(1'b1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
        .in_mask(in_mask1), .flush(flush1), .out_valid(out_valid1),
        .out_ready(out_ready1), .out_idx(out_idx1), .out_last(out_last1),
        .empty_pls(empty_pls1), .emit_cnt(emit_cnt1)
    );

    int checks = 0;
    int errors = 0;
    exp_t q0[$];
    exp_t q1[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitors: a beat is taken on the next rising edge when valid & ready
    // and no flush/reset is pending.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && !flush0 && out_valid0 && out_ready0) begin
            if (q0.size() == 0) begin
                checks++; errors++;
                $display("FAIL beat0_unexpected: got idx %0d expected no beat", out_idx0);
            end else begin
                e = q0.pop_front();
                check("beat0_idx", 32'(out_idx0), 32'(e.idx));
                check("beat0_last", 32'(out_last0), 32'(e.last));
                check("beat0_cnt", 32'(emit_cnt0), 32'(e.cnt));
            end
        end
        if (!rst && !flush1 && out_valid1 && out_ready1) begin
            if (q1.size() == 0) begin
                checks++; errors++;
                $display("FAIL beat1_unexpected: got idx %0d expected no beat", out_idx1);
            end else begin
                e = q1.pop_front();
                check("beat1_idx", 32'(out_idx1), 32'(e.idx));
                check("beat1_last", 32'(out_last1), 32'(e.last));
                check("beat1_cnt", 32'(emit_cnt1), 32'(e.cnt));
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send0(input logic [31:0] m);
        in_valid0 = 1'b1;
        in_mask0  = m;
        tick(1);
        in_valid0 = 1'b0;
        in_mask0  = 32'hDEAD_BEEF;   // must be ignored while scanning
    endtask

    initial begin
        // Reset values
        tick(2);
        check("rst_out_valid", 32'(out_valid0), 0);
        check("rst_in_ready", 32'(in_ready0), 1);
        check("rst_emit_cnt", 32'(emit_cnt0), 0);
        check("rst_empty_pls", 32'(empty_pls0), 0);
        check("rst_out_idx", 32'(out_idx0), 0);
        check("rst_out_last", 32'(out_last0), 0);
        rst = 1'b0;
        tick(1);

        // 1: reset mid-stream after two beats of 0x0F00
        q0.push_back('{idx: 5'd8, last: 1'b0, cnt: 6'd0});
        q0.push_back('{idx: 5'd9, last: 1'b0, cnt: 6'd1});
        send0(32'h0000_0F00);
        tick(2);
        rst = 1'b1;
        #1;
        check("midrst_out_valid", 32'(out_valid0), 0);
        check("midrst_in_ready", 32'(in_ready0), 1);
        check("midrst_emit_cnt", 32'(emit_cnt0), 0);
        tick(1);
        rst = 1'b0;
        tick(1);

        // 2: 0x8000_0011 lowest-first
        q0.push_back('{idx: 5'd0,  last: 1'b0, cnt: 6'd0});
        q0.push_back('{idx: 5'd4,  last: 1'b0, cnt: 6'd1});
        q0.push_back('{idx: 5'd31, last: 1'b1, cnt: 6'd2});
        send0(32'h8000_0011);
        tick(3);
        check("t2_emit_cnt", 32'(emit_cnt0), 3);
        check("t2_in_ready", 32'(in_ready0), 1);
        check("t2_out_valid", 32'(out_valid0), 0);

        // 3: same mask highest-first
        q1.push_back('{idx: 5'd31, last: 1'b0, cnt: 6'd0});
        q1.push_back('{idx: 5'd4,  last: 1'b0, cnt: 6'd1});
        q1.push_back('{idx: 5'd0,  last: 1'b1, cnt: 6'd2});
        in_valid1 = 1'b1;
        in_mask1  = 32'h8000_0011;
        tick(1);
        in_valid1 = 1'b0;
        in_mask1  = '0;
        tick(3);
        check("t3_emit_cnt", 32'(emit_cnt1), 3);
        check("t3_in_ready", 32'(in_ready1), 1);

        // 4: backpressure on 0x6
        out_ready0 = 1'b0;
        q0.push_back('{idx: 5'd1, last: 1'b0, cnt: 6'd0});
        q0.push_back('{idx: 5'd2, last: 1'b1, cnt: 6'd1});
        send0(32'h0000_0006);
        for (int i = 0; i < 3; i++) begin
            check("t4_hold_valid", 32'(out_valid0), 1);
            check("t4_hold_idx", 32'(out_idx0), 1);
            check("t4_hold_last", 32'(out_last0), 0);
            check("t4_hold_cnt", 32'(emit_cnt0), 0);
            tick(1);
        end
        out_ready0 = 1'b1;
        tick(2);
        check("t4_emit_cnt", 32'(emit_cnt0), 2);
        check("t4_in_ready", 32'(in_ready0), 1);

        // 5: zero mask
        send0(32'h0000_0000);
        check("t5_empty_pls", 32'(empty_pls0), 1);
        check("t5_out_valid", 32'(out_valid0), 0);
        check("t5_in_ready", 32'(in_ready0), 1);
        tick(1);
        check("t5_empty_pls_end", 32'(empty_pls0), 0);
        check("t5_out_valid_end", 32'(out_valid0), 0);

        // 6: full mask, then flush at beat 10 of a second full mask
        for (int i = 0; i < 32; i++)
            q0.push_back('{idx: 5'(i), last: (i == 31), cnt: 6'(i)});
        send0(32'hFFFF_FFFF);
        tick(32);
        check("t6_emit_cnt", 32'(emit_cnt0), 32);
        check("t6_in_ready", 32'(in_ready0), 1);
        for (int i = 0; i < 10; i++)
            q0.push_back('{idx: 5'(i), last: 1'b0, cnt: 6'(i)});
        send0(32'hFFFF_FFFF);
        tick(10);
        check("t6_pre_flush_idx", 32'(out_idx0), 10);
        check("t6_pre_flush_cnt", 32'(emit_cnt0), 10);
        flush0 = 1'b1;
        tick(1);
        flush0 = 1'b0;
        check("t6_flush_out_valid", 32'(out_valid0), 0);
        check("t6_flush_in_ready", 32'(in_ready0), 1);
        check("t6_flush_emit_cnt", 32'(emit_cnt0), 0);
        tick(2);

        check("q0_drained", 32'(q0.size()), 0);
        check("q1_drained", 32'(q1.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
